uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a mid-bit sampling FSM, a one-entry
// holding register (data_out/data_valid), a sticky overrun flag and a
// single-cycle framing-error pulse. rx is resynchronised before use.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | confirming the start bit at its midpoint (glitch filter)
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | sampling the stop bit; commit or flag a framing error
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync2_q;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            commit;
  logic            rx_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: half-bit wait in START lands every later sample at mid-bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    commit      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a commit wins over rd, so a same-cycle rd never drops the new byte.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    if (commit) begin
      data_out_d   = shift_q;
      data_valid_d = 1'b1;
      overrun_d    = overrun_q | (data_valid_q & ~rd);
    end else if (rd && data_valid_q) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit. Inputs change 1 time unit
// after a rising edge, so a frame launched there has t0 = the next edge and
// its commit lands on edge t0+154.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int busy_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with frame_err / busy high.
  always @(posedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (busy)      busy_cnt = busy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    rx    = 1'b1;
    rd    = 1'b0;
    rst_n = 1'b0;
    #3;
    check_eq("rst_data_out", 32'(data_out), 32'h00);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);

    // 0xA5 with exact commit timing
    fe_cnt = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(154);
        check_eq("a5_valid_early", 32'(data_valid), 32'h0);
        wait_cyc(1);
        check_eq("a5_valid_t154", 32'(data_valid), 32'h1);
        check_eq("a5_data", 32'(data_out), 32'hA5);
        wait_cyc(1);
        check_eq("a5_busy_after", 32'(busy), 32'h0);
      end
    join
    check_eq("a5_no_frame_err", 32'(fe_cnt), 32'd0);
    pulse_rd();
    wait_cyc(1);
    check_eq("a5_rd_clears", 32'(data_valid), 32'h0);

    // 5-cycle glitch is rejected
    wait_cyc(8);
    busy_cnt = 0;
    fe_cnt   = 0;
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(30);
    check_eq("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    check_eq("glitch_no_valid", 32'(data_valid), 32'h0);
    check_eq("glitch_no_frame_err", 32'(fe_cnt), 32'd0);

    // 0x3C with a low stop bit, line held low, then 0x55
    fe_cnt = 0;
    send_frame(8'h3C, 1'b0);
    wait_cyc(40 * CPB);
    check_eq("brk_busy_wait_high", 32'(busy), 32'h1);
    check_eq("brk_frame_err_once", 32'(fe_cnt), 32'd1);
    check_eq("brk_no_valid", 32'(data_valid), 32'h0);
    check_eq("brk_data_kept", 32'(data_out), 32'hA5);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    check_eq("brk_back_idle", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1);
    wait_cyc(4);
    check_eq("post_brk_data", 32'(data_out), 32'h55);
    check_eq("post_brk_valid", 32'(data_valid), 32'h1);
    check_eq("post_brk_fe_total", 32'(fe_cnt), 32'd1);
    pulse_rd();
    wait_cyc(CPB);

    // back-to-back 0x01, 0x02 without rd -> overrun
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    wait_cyc(4);
    check_eq("b2b_data", 32'(data_out), 32'h02);
    check_eq("b2b_valid", 32'(data_valid), 32'h1);
    check_eq("b2b_overrun", 32'(overrun), 32'h1);
    pulse_rd();
    wait_cyc(1);
    check_eq("b2b_rd_valid", 32'(data_valid), 32'h0);
    check_eq("b2b_rd_overrun", 32'(overrun), 32'h0);
    pulse_rd();
    wait_cyc(1);
    check_eq("rd_idle_no_effect", 32'(data_valid), 32'h0);
    wait_cyc(CPB);

    // rd on the commit cycle of 0xFF while 0x11 is still pending
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cyc(154);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
        check_eq("rdcommit_valid", 32'(data_valid), 32'h1);
        check_eq("rdcommit_data", 32'(data_out), 32'hFF);
        check_eq("rdcommit_overrun", 32'(overrun), 32'h0);
      end
    join
    pulse_rd();
    wait_cyc(CPB);

    // reset during data bit 4 of 0x96, then 0x69
    fork
      send_frame(8'h96, 1'b1);
      begin
        wait_cyc(86);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_data", 32'(data_out), 32'h00);
        check_eq("mid_rst_valid", 32'(data_valid), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'h0);
      end
    join
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3 * CPB);
    check_eq("post_rst_no_commit", 32'(data_valid), 32'h0);
    check_eq("post_rst_data", 32'(data_out), 32'h00);
    send_frame(8'h69, 1'b1);
    wait_cyc(4);
    check_eq("post_rst_69_data", 32'(data_out), 32'h69);
    check_eq("post_rst_69_valid", 32'(data_valid), 32'h1);
    check_eq("post_rst_69_overrun", 32'(overrun), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
